// File: rtl/packet_filter.sv
`default_nettype none
// ============================================================================
//  Module   : packet_filter
//  Purpose  : Word-serial receive front end. Assembles fixed-format packets
//             from the radio word stream, drops packets with an invalid type
//             or not addressed to this node (unicast myNodeID or broadcast),
//             and presents the accepted fields with a one-cycle pkt_valid
//             strobe. Also derives channel_clear from receive-idle time.
//  Ports    : clk, rst (async, active high)
//             rx_valid / rx_sop / rx_data   - incoming word stream
//             myNodeID                      - this node's address
//             fPacketType .. fEnergy        - last accepted packet fields
//             pkt_valid / pkt_drop          - one-cycle result strobes
//             busy                          - packet in RECV or CHECK
//             channel_clear                 - medium idle >= CLEAR_CYCLES
//  Options  : PKT_CHECKSUM_EN - 8-word packets, W7 = XOR of W0..W6
//  Revision : 1.0  initial release
// ============================================================================
module packet_filter #(
   parameter int                    WORD_WIDTH     = 16,
   parameter int                    CLEAR_CYCLES   = 8,
   parameter int                    TIMEOUT_CYCLES = 32,
   parameter logic [WORD_WIDTH-1:0] BROADCAST_ID   = {WORD_WIDTH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic                  rx_sop,
   input  logic [WORD_WIDTH-1:0] rx_data,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   output logic [2:0]            fPacketType,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] destinationID,
   output logic [WORD_WIDTH-1:0] fHopsFromCH,
   output logic [WORD_WIDTH-1:0] fChosenCH,
   output logic [WORD_WIDTH-1:0] fTimeslot,
   output logic [WORD_WIDTH-1:0] fEnergy,
   output logic                  pkt_valid,
   output logic                  pkt_drop,
   output logic                  busy,
   output logic                  channel_clear
);

`ifdef PKT_CHECKSUM_EN
   localparam int LAST = 7;
`else
   localparam int LAST = 6;
`endif
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW = $clog2(CLEAR_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t                state_q;
   logic [2:0]            count_q;
   logic [GW-1:0]         gap_q;
   logic [2:0]            type_sh_q;                 // W0 only contributes its type bits
   logic [WORD_WIDTH-1:0] shadow_q [1:LAST];
   logic                  pend_acc_q;
   logic                  pend_drop_q;
   logic                  busy_q;
   logic                  pkt_valid_q;
   logic                  pkt_drop_q;
   logic [2:0]            ftype_q;
   logic [WORD_WIDTH-1:0] fsrc_q, fdst_q, fhops_q, fch_q, fts_q, fen_q;
   logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
   logic                  chan_clear_q;
`ifdef PKT_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] xor_q;
`endif

   logic w_type_ok, w_dest_ok, w_accept;

   assign w_type_ok = (type_sh_q >= 3'd1) && (type_sh_q <= 3'd5);
   assign w_dest_ok = (shadow_q[2] == myNodeID) || (shadow_q[2] == BROADCAST_ID);
`ifdef PKT_CHECKSUM_EN
   assign w_accept  = w_type_ok && w_dest_ok && (shadow_q[LAST] == xor_q);
`else
   assign w_accept  = w_type_ok && w_dest_ok;
`endif

   // ------------------------------------------------------------------------
   // Packet FSM. The CHECK decision is latched into pend_* and applied one
   // cycle later, so results appear two edges after the last word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         gap_q       <= '0;
         type_sh_q   <= '0;
         for (int i = 1; i <= LAST; i++) shadow_q[i] <= '0;
         pend_acc_q  <= 1'b0;
         pend_drop_q <= 1'b0;
         busy_q      <= 1'b0;
         pkt_valid_q <= 1'b0;
         pkt_drop_q  <= 1'b0;
         ftype_q     <= '0;
         fsrc_q      <= '0;
         fdst_q      <= '0;
         fhops_q     <= '0;
         fch_q       <= '0;
         fts_q       <= '0;
         fen_q       <= '0;
`ifdef PKT_CHECKSUM_EN
         xor_q       <= '0;
`endif
      end else begin
         pkt_valid_q <= pend_acc_q;
         pkt_drop_q  <= pend_drop_q;
         pend_acc_q  <= 1'b0;
         pend_drop_q <= 1'b0;

         if (pend_acc_q) begin
            ftype_q <= type_sh_q;
            fsrc_q  <= shadow_q[1];
            fdst_q  <= shadow_q[2];
            fhops_q <= shadow_q[3];
            fch_q   <= shadow_q[4];
            fts_q   <= shadow_q[5];
            fen_q   <= shadow_q[6];
         end

         case (state_q)
            S_IDLE: begin
               if (rx_valid && rx_sop) begin
                  type_sh_q <= rx_data[2:0];
                  count_q   <= 3'd1;
                  gap_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_RECV;
`ifdef PKT_CHECKSUM_EN
                  xor_q     <= rx_data;
`endif
               end
            end

            S_RECV: begin
               if (rx_valid) begin
                  gap_q <= '0;
                  if (rx_sop) begin
                     // Abandon the partial packet; this word is a fresh W0.
                     pkt_drop_q <= 1'b1;
                     type_sh_q  <= rx_data[2:0];
                     count_q    <= 3'd1;
`ifdef PKT_CHECKSUM_EN
                     xor_q      <= rx_data;
`endif
                  end else begin
                     shadow_q[count_q] <= rx_data;
                     if (count_q == 3'(LAST)) begin
                        state_q <= S_CHECK;
                     end else begin
                        count_q <= count_q + 3'd1;
`ifdef PKT_CHECKSUM_EN
                        xor_q   <= xor_q ^ rx_data;
`endif
                     end
                  end
               end else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                  pkt_drop_q <= 1'b1;
                  gap_q      <= '0;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end

            S_CHECK: begin
               pend_acc_q  <= w_accept;
               pend_drop_q <= ~w_accept;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Idle-time tracking for channel_clear (saturating counter).
   // ------------------------------------------------------------------------
   always_comb begin
      idle_cnt_d = '0;
      if ((state_q == S_IDLE) && !rx_valid) begin
         idle_cnt_d = (idle_cnt_q == IW'(CLEAR_CYCLES)) ? idle_cnt_q
                                                        : idle_cnt_q + IW'(1);
      end
   end

   // Registered from the next count so clear drops right after rx_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q   <= '0;
         chan_clear_q <= 1'b0;
      end else begin
         idle_cnt_q   <= idle_cnt_d;
         chan_clear_q <= (idle_cnt_d == IW'(CLEAR_CYCLES));
      end
   end

   assign fPacketType   = ftype_q;
   assign fSourceID     = fsrc_q;
   assign destinationID = fdst_q;
   assign fHopsFromCH   = fhops_q;
   assign fChosenCH     = fch_q;
   assign fTimeslot     = fts_q;
   assign fEnergy       = fen_q;
   assign pkt_valid     = pkt_valid_q;
   assign pkt_drop      = pkt_drop_q;
   assign busy          = busy_q;
   assign channel_clear = chan_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packet_filter
//  Purpose  : Self-checking bench for packet_filter (directed + random
//             packets against a field-level reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_packet_filter;

`ifdef PKT_CHECKSUM_EN
   localparam int LASTW = 7;
`else
   localparam int LASTW = 6;
`endif

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic        rx_sop;
   logic [15:0] rx_data;
   logic [15:0] myNodeID;
   logic [2:0]  fPacketType;
   logic [15:0] fSourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot, fEnergy;
   logic        pkt_valid, pkt_drop, busy, channel_clear;

   packet_filter #(
      .WORD_WIDTH     (16),
      .CLEAR_CYCLES   (8),
      .TIMEOUT_CYCLES (32),
      .BROADCAST_ID   (16'hFFFF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_valid      (rx_valid),
      .rx_sop        (rx_sop),
      .rx_data       (rx_data),
      .myNodeID      (myNodeID),
      .fPacketType   (fPacketType),
      .fSourceID     (fSourceID),
      .destinationID (destinationID),
      .fHopsFromCH   (fHopsFromCH),
      .fChosenCH     (fChosenCH),
      .fTimeslot     (fTimeslot),
      .fEnergy       (fEnergy),
      .pkt_valid     (pkt_valid),
      .pkt_drop      (pkt_drop),
      .busy          (busy),
      .channel_clear (channel_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] pw [0:7];                 // packet being sent
   logic [2:0]  e_type;                   // model: last accepted fields
   logic [15:0] e_src, e_dst, e_hops, e_ch, e_ts, e_en;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_fields(input string tag);
      chk({tag, ":type"},  32'(fPacketType),   32'(e_type));
      chk({tag, ":src"},   32'(fSourceID),     32'(e_src));
      chk({tag, ":dst"},   32'(destinationID), 32'(e_dst));
      chk({tag, ":hops"},  32'(fHopsFromCH),   32'(e_hops));
      chk({tag, ":ch"},    32'(fChosenCH),     32'(e_ch));
      chk({tag, ":ts"},    32'(fTimeslot),     32'(e_ts));
      chk({tag, ":en"},    32'(fEnergy),       32'(e_en));
   endtask

   task automatic make_pkt(input logic [15:0] w0, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] hops, input logic [15:0] ch, input logic [15:0] ts,
                           input logic [15:0] en);
      pw[0] = w0; pw[1] = src; pw[2] = dst; pw[3] = hops;
      pw[4] = ch; pw[5] = ts;  pw[6] = en;
      pw[7] = w0 ^ src ^ dst ^ hops ^ ch ^ ts ^ en;
   endtask

   // Reference decision computed straight from the packet contents.
   function automatic bit model_accept();
      int  t;
      bit  ok;
      t  = int'(pw[0][2:0]);
      ok = (t >= 1) && (t <= 5) && ((pw[2] == myNodeID) || (pw[2] == 16'hFFFF));
`ifdef PKT_CHECKSUM_EN
      ok = ok && (pw[7] == (pw[0] ^ pw[1] ^ pw[2] ^ pw[3] ^ pw[4] ^ pw[5] ^ pw[6]));
`endif
      return ok;
   endfunction

   // Send words lo..hi of pw, with 'gap' idle cycles before each word.
   task automatic send_range(input int lo, input int hi, input int gap);
      for (int i = lo; i <= hi; i++) begin
         rx_valid = 1'b0;
         rx_sop   = 1'b0;
         repeat (gap) tick();
         rx_valid = 1'b1;
         rx_sop   = (i == 0);
         rx_data  = pw[i];
         tick();
      end
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
   endtask

   // Called just after the edge that sampled the last word.
   task automatic expect_result(input bit acc, input string tag);
      chk({tag, ":busy_check"}, 32'(busy), 32'd1);
      chk({tag, ":valid_n"},    32'(pkt_valid), 32'd0);
      tick();
      chk({tag, ":busy_n1"},    32'(busy), 32'd0);
      chk({tag, ":valid_n1"},   32'(pkt_valid), 32'd0);
      chk({tag, ":drop_n1"},    32'(pkt_drop), 32'd0);
      tick();
      if (acc) begin
         e_type = pw[0][2:0]; e_src = pw[1]; e_dst = pw[2]; e_hops = pw[3];
         e_ch   = pw[4];      e_ts  = pw[5]; e_en  = pw[6];
      end
      chk({tag, ":valid_n2"}, 32'(pkt_valid), 32'(acc));
      chk({tag, ":drop_n2"},  32'(pkt_drop),  32'(!acc));
      check_fields(tag);
      tick();
      chk({tag, ":valid_n3"}, 32'(pkt_valid), 32'd0);
      chk({tag, ":drop_n3"},  32'(pkt_drop),  32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ":valid"}, 32'(pkt_valid), 32'd0);
      chk({tag, ":drop"},  32'(pkt_drop), 32'd0);
      chk({tag, ":busy"},  32'(busy), 32'd0);
      chk({tag, ":clear"}, 32'(channel_clear), 32'd0);
      check_fields(tag);
   endtask

   initial begin
      logic [31:0] r;
      logic [2:0]  t;
      logic [15:0] d;
      bit          acc;

      e_type = '0; e_src = '0; e_dst = '0; e_hops = '0; e_ch = '0; e_ts = '0; e_en = '0;
      rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_data = '0; myNodeID = 16'h0003;
      tick(); tick();
      check_all_zero("reset");

      // Idle time -> channel_clear
      rst = 1'b0;
      repeat (7) tick();
      chk("clear_7", 32'(channel_clear), 32'd0);
      tick();
      chk("clear_8", 32'(channel_clear), 32'd1);
      rx_valid = 1'b1; rx_sop = 1'b0; rx_data = 16'h1234;
      tick();
      rx_valid = 1'b0;
      chk("clear_drop", 32'(channel_clear), 32'd0);
      chk("nosop_busy", 32'(busy), 32'd0);
      tick();
      chk("nosop_drop", 32'(pkt_drop), 32'd0);
      repeat (6) tick();
      chk("reclear_7", 32'(channel_clear), 32'd0);
      tick();
      chk("reclear_8", 32'(channel_clear), 32'd1);

      // Unicast to own ID
      make_pkt(16'h0001, 16'h0009, 16'h0003, 16'h0002, 16'h0005, 16'h0004, 16'h8000);
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t1_unicast");

      // Wrong destination, then broadcast
      make_pkt(16'h0001, 16'h0009, 16'h0007, 16'h0002, 16'h0005, 16'h0004, 16'h8000);
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t2_otherdest");
      make_pkt(16'h0001, 16'h0009, 16'hFFFF, 16'h0002, 16'h0005, 16'h0004, 16'h8000);
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t2_bcast");

      // Invalid type, gapped packet, timeout
      make_pkt(16'h0006, 16'h0011, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t3_type6");
      make_pkt(16'hABC2, 16'h0021, 16'h0003, 16'h0007, 16'h0008, 16'h0009, 16'h4444);
      send_range(0, LASTW, 3);
      expect_result(model_accept(), "t3_gaps");
      make_pkt(16'h0003, 16'h0055, 16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      send_range(0, 3, 0);
      repeat (31) tick();
      chk("t3_to_before_drop", 32'(pkt_drop), 32'd0);
      chk("t3_to_before_busy", 32'(busy), 32'd1);
      tick();
      chk("t3_to_drop", 32'(pkt_drop), 32'd1);
      chk("t3_to_busy", 32'(busy), 32'd0);
      chk("t3_to_valid", 32'(pkt_valid), 32'd0);
      check_fields("t3_to");
      tick();
      chk("t3_to_drop_end", 32'(pkt_drop), 32'd0);

      // Restart mid-packet
      make_pkt(16'h0002, 16'h0066, 16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      send_range(0, 3, 0);
      make_pkt(16'h0004, 16'h0077, 16'h0003, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
      rx_valid = 1'b1; rx_sop = 1'b1; rx_data = pw[0];
      tick();
      rx_valid = 1'b0; rx_sop = 1'b0;
      chk("t4_restart_drop", 32'(pkt_drop), 32'd1);
      chk("t4_restart_busy", 32'(busy), 32'd1);
      send_range(1, LASTW, 0);
      expect_result(model_accept(), "t4_second");

`ifdef PKT_CHECKSUM_EN
      make_pkt(16'h0005, 16'h0101, 16'h0003, 16'h0202, 16'h0303, 16'h0404, 16'h0505);
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t6_csum_ok");
      make_pkt(16'h0005, 16'h0111, 16'h0003, 16'h0202, 16'h0303, 16'h0404, 16'h0505);
      pw[7] = pw[7] ^ 16'h0100;
      send_range(0, LASTW, 0);
      expect_result(model_accept(), "t6_csum_bad");
`endif

      // Random packets
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) myNodeID = 16'($urandom());
         r = $urandom();
         t = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(1, 5)) : r[18:16];
         case ($urandom_range(0, 3))
            0, 1:    d = myNodeID;
            2:       d = 16'hFFFF;
            default: d = 16'($urandom());
         endcase
         make_pkt({r[15:3], t}, 16'($urandom()), d, 16'($urandom()),
                  16'($urandom()), 16'($urandom()), 16'($urandom()));
         if ($urandom_range(0, 5) == 0) pw[7] = pw[7] ^ 16'(1 << $urandom_range(0, 15));
         acc = model_accept();
         send_range(0, LASTW, int'($urandom_range(0, 2)));
         expect_result(acc, $sformatf("rnd%0d", k));
      end

      // Reset in the middle of a packet
      myNodeID = 16'h0003;
      make_pkt(16'h0001, 16'h0099, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
      send_range(0, 3, 0);
      rst = 1'b1;
      #1;
      e_type = '0; e_src = '0; e_dst = '0; e_hops = '0; e_ch = '0; e_ts = '0; e_en = '0;
      check_all_zero("t5_midreset");
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_post_valid", 32'(pkt_valid), 32'd0);
         chk("t5_post_drop",  32'(pkt_drop), 32'd0);
         chk("t5_post_busy",  32'(busy), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/packet_filter.md
Name: packet_filter

Overview:
- Word-serial receive front end directly upstream of the node controller.
- Assembles fixed-format packets from the radio word stream and drops packets not addressed to this node (unicast to myNodeID, or broadcast).
- Presents registered packet fields (fPacketType, fHopsFromCH, fChosenCH, fTimeslot, destinationID, ...) with a one-cycle pkt_valid strobe.
- Generates channel_clear from receive-idle time.

Parameters:
WORD_WIDTH, 16, width of every packet word and ID field
CLEAR_CYCLES, 8, consecutive idle cycles before channel_clear asserts (>=1)
TIMEOUT_CYCLES, 32, max rx_valid gap inside a packet before abort (>=1)
BROADCAST_ID, 16'hFFFF, destination value accepted by every node

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  rx_data carries a word this cycle
rx_sop  in  1  qualifies rx_valid: word is W0 of a new packet
rx_data  in  WORD_WIDTH  received word
myNodeID  in  WORD_WIDTH  this node's ID (from MNI)
fPacketType  out  3  accepted packet type
fSourceID  out  WORD_WIDTH  accepted source ID
destinationID  out  WORD_WIDTH  accepted destination ID
fHopsFromCH  out  WORD_WIDTH  accepted hop count
fChosenCH  out  WORD_WIDTH  accepted sender's chosen CH
fTimeslot  out  WORD_WIDTH  accepted timeslot
fEnergy  out  WORD_WIDTH  accepted sender residual energy
pkt_valid  out  1  one-cycle strobe: fields updated with a new accepted packet
pkt_drop  out  1  one-cycle strobe: packet discarded
busy  out  1  high in RECV/CHECK
channel_clear  out  1  medium idle for >= CLEAR_CYCLES

Behaviour:
- Packet format, 7 words in order:
  - W0 header: [2:0] type, [15:3] ignored
  - W1 source, W2 destination, W3 hops, W4 chosenCH, W5 timeslot, W6 energy
- Valid types: 1..5. Types 0, 6, 7 are dropped.
- Reset: all outputs 0. State IDLE; word counter, gap counter and idle counter 0.
- FSM IDLE:
  - rx_valid&rx_sop: store W0 in shadow register, count=1, -> RECV.
  - rx_valid without rx_sop: ignored, no strobe.
- FSM RECV:
  - Each rx_valid word goes to shadow[count]; count increments.
  - rx_valid low: hold state and increment the gap counter. The gap counter clears on any rx_valid.
  - Last word (count==6) sampled: -> CHECK.
  - rx_sop&rx_valid mid-packet: pkt_drop pulses next cycle. The word restarts a new packet as W0, count=1, stays RECV.
  - Gap counter reaches TIMEOUT_CYCLES: pkt_drop pulse, -> IDLE.
- FSM CHECK (one cycle, rx input ignored):
  - Accept when type valid AND (dest==myNodeID OR dest==BROADCAST_ID).
  - Accept: copy shadow to output registers, pkt_valid=1 for exactly one cycle.
  - Otherwise: pkt_drop=1 for one cycle, outputs unchanged.
  - -> IDLE.
- Latency: last word sampled at edge N; pkt_valid/fields visible after edge N+2. pkt_valid and pkt_drop are never both high.
- Output fields hold the last accepted packet until the next accept. A dropped packet never alters them.
- A word offered while in CHECK is lost. Upstream guarantees at least one idle cycle after each packet.
- channel_clear:
  - Idle counter increments each cycle that state==IDLE and rx_valid==0, saturating at CLEAR_CYCLES.
  - Any rx_valid or non-IDLE state clears it.
  - channel_clear = (counter==CLEAR_CYCLES), registered. It deasserts the cycle after rx_valid is seen.
- Reset asserted mid-packet: immediate return to reset values. No strobe is generated.

Optional Feature:
PKT_CHECKSUM_EN:
- Defined: packet is 8 words; W7 = XOR of W0..W6. Running XOR is kept in RECV. CHECK additionally requires a checksum match, otherwise pkt_drop.
- Undefined: 7-word packets, no checksum logic.

Test Plan:
1. myNodeID=16'h0003; packet {0001,0009,0003,0002,0005,0004,8000} contiguous -> pkt_valid one cycle at last-word edge +2. Fields: type=1, source=0009, dest=0003, hops=0002, chosenCH=0005, timeslot=0004, energy=8000. pkt_drop=0.
2. Same packet with dest=0007 -> pkt_drop one cycle, pkt_valid 0, fields retain test-1 values. Then dest=FFFF -> accepted.
3. Type W0=0006 to own ID -> pkt_drop. Packet with rx_valid gaps of 3 cycles between words -> accepted normally. Gap of 32 cycles after W3 -> pkt_drop, busy=0, fields unchanged.
4. rx_sop reasserted at W4 of a packet, followed by a full valid packet -> one pkt_drop, then one pkt_valid carrying the second packet.
5. After reset, rx_valid low -> channel_clear=1 after 8 idle cycles. Single rx_valid word without sop -> channel_clear low next cycle, re-asserts 8 cycles later. Reset asserted mid-packet -> all outputs 0, no strobe.
6. (PKT_CHECKSUM_EN) correct W7 -> pkt_valid. W7 with one bit flipped -> pkt_drop.
